// File: rtl/disp_scan_if.sv
// disp_scan_if: control and drive bundle for the display scanner.
// DIGITS sets the width of the value, dp and digit-select lanes.
interface disp_scan_if #(
    parameter int DIGITS = 8
);
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_mask;
    logic                  load;
    logic                  ack;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     dig_sel;

    modport master (
        output en, value, dp_mask, load,
        input  ack, seg, dig_sel
    );

    modport slave (
        input  en, value, dp_mask, load,
        output ack, seg, dig_sel
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed 7-segment scanner with guard blanking and
// frame-synchronous commit. Option macro: DISP_LZ_BLANK_EN (leading-zero blank).
module disp_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV    = 1000,
    parameter int GUARD  = 16
) (
    input logic        clock,
    input logic        reset,
    disp_scan_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [15:0]   CNT_LAST = 16'(DIV - 1);
    localparam logic [15:0]   CNT_GEND = 16'(GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic {ST_GUARD, ST_SHOW} state_t;

    state_t                 state, state_d;
    logic [15:0]            cnt;
    logic [IW-1:0]          idx;
    logic [DIGITS-1:0][3:0] held, shadow;
    logic [DIGITS-1:0]      held_dp, shadow_dp;
    logic                   pending;
    logic                   tick, boundary, commit;
    logic [7:0]             seg_d, seg_q;
    logic [DIGITS-1:0]      onehot, dig_q;
    logic                   ack_q;
`ifdef DISP_LZ_BLANK_EN
    logic [DIGITS-1:0]      nz;
    logic                   acc;
`endif

    function automatic logic [7:0] decode(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h1A;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick     = bus.en && (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);
    assign commit   = boundary && pending;

    // Slot phase: blank guard first, then show until the slot ends.
    always_comb begin
        state_d = state;
        if (bus.en) begin
            unique case (state)
                ST_GUARD: if (cnt == CNT_GEND) state_d = ST_SHOW;
                ST_SHOW:  if (tick) state_d = ST_GUARD;
            endcase
        end
    end

    // Segment pattern and digit strobe for the current slot.
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        seg_d       = decode(shadow[idx]);
`ifdef DISP_LZ_BLANK_EN
        nz  = '0;
        acc = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc   = acc | (|shadow[k]);
            nz[k] = acc;
        end
        if (idx != '0 && !nz[idx]) seg_d[7:1] = '0;
`endif
        seg_d[0] = shadow_dp[idx];
    end

    // Prescaler, digit index and phase; all frozen while en is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_GUARD;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            if (bus.en) cnt <= tick ? '0 : cnt + 16'd1;
            if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Held/shadow double buffer; shadow only moves at a frame boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held      <= '0;
            held_dp   <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            pending   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            if (commit) begin
                shadow    <= held;
                shadow_dp <= held_dp;
            end
            if (bus.load) begin
                held    <= bus.value;
                held_dp <= bus.dp_mask;
            end
            pending <= bus.load | (pending & ~commit);
            ack_q   <= commit;
        end
    end

    // Registered drivers: lit only while enabled and in the show phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q <= '0;
            dig_q <= '0;
        end else if (bus.en && state_d == ST_SHOW) begin
            seg_q <= seg_d;
            dig_q <= onehot;
        end else begin
            seg_q <= '0;
            dig_q <= '0;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dig_sel = dig_q;
    assign bus.ack     = ack_q;
endmodule
